// File: rtl/pc_fetch_pkg.sv
// -----------------------------------------------------------------------------
// pc_fetch_pkg
// Shared types and constants for the program-counter fetch unit.
//   branch_mode_t : encoding of the branch_mode bus driven by execute
//                   (codes 6 and 7 are unused and behave as NONE).
//   fetch_state_t : fetch sequencer states.
//   PC_SHIFT      : word-offset to byte-offset scaling (log2 of 4-byte words).
// -----------------------------------------------------------------------------
package pc_fetch_pkg;

  typedef enum logic [2:0] {
    BM_NONE = 3'd0,
    BM_B    = 3'd1,
    BM_BL   = 3'd2,
    BM_CBZ  = 3'd3,
    BM_CBNZ = 3'd4,
    BM_BR   = 3'd5
  } branch_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_PENDING = 2'd2
  } fetch_state_t;

  localparam int PC_SHIFT = 2;

endpackage

// File: rtl/pc_branch_resolve.sv
// -----------------------------------------------------------------------------
// pc_branch_resolve
// Purely combinational branch resolution: decides whether a control transfer
// is taken and computes its byte target.
// Ports:
//   i_mode       : branch mode code (see branch_mode_t)
//   i_flag       : ALU zero flag, used by CBZ / CBNZ
//   i_base       : PC of the branching instruction
//   i_offset     : sign-extended word offset
//   i_reg_target : absolute byte target for BR
//   o_taken      : transfer is taken (caller qualifies with branch_valid)
//   o_target     : byte target, modulo 2^ADDR_WIDTH
//   o_is_link    : mode is BL
// -----------------------------------------------------------------------------
module pc_branch_resolve
  import pc_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic        [2:0]            i_mode,
  input  logic                         i_flag,
  input  logic        [ADDR_WIDTH-1:0] i_base,
  input  logic signed [ADDR_WIDTH-1:0] i_offset,
  input  logic        [ADDR_WIDTH-1:0] i_reg_target,
  output logic                         o_taken,
  output logic        [ADDR_WIDTH-1:0] o_target,
  output logic                         o_is_link
);

  logic signed [ADDR_WIDTH-1:0] w_off_scaled;

  always_comb begin
    o_taken = 1'b0;
    case (i_mode)
      BM_B, BM_BL, BM_BR: o_taken = 1'b1;
      BM_CBZ:             o_taken = i_flag;
      BM_CBNZ:            o_taken = ~i_flag;
      default:            o_taken = 1'b0;
    endcase
  end

  // Arithmetic shift keeps the sign of the word offset; the add wraps freely.
  assign w_off_scaled = i_offset <<< PC_SHIFT;
  assign o_target     = (i_mode == BM_BR) ? i_reg_target
                                          : i_base + $unsigned(w_off_scaled);
  assign o_is_link    = (i_mode == BM_BL);

endmodule

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
// Generates instruction-fetch addresses with a valid/ready handshake, applies
// resolved branches from execute, buffers one redirect while fetch is stalled,
// and produces the BL link address and the pipeline flush pulse.
// Optional build macro: PC_ALIGN_CHECK_EN adds o_align_fault and drops taken
// branches whose target is not word aligned; without it the target's two low
// bits are forced to zero.
// Ports:
//   i_clock, i_reset       : clock, synchronous active-high reset
//   i_branch_valid         : execute presents a resolved control transfer
//   i_branch_mode          : 0=NONE 1=B 2=BL 3=CBZ 4=CBNZ 5=BR (6,7 = NONE)
//   i_zero_flag            : ALU zero for CBZ/CBNZ
//   i_branch_base          : PC of the branching instruction
//   i_branch_offset        : sign-extended word offset
//   i_reg_target           : absolute byte target for BR
//   i_fetch_ready          : instruction memory accepts o_read_address
//   o_fetch_valid          : o_read_address is a valid request
//   o_read_address         : fetch address
//   o_redirect_taken       : one-cycle flush pulse
//   o_link_address         : branch_base + INSTR_BYTES of the last taken BL
//   o_link_valid           : one-cycle pulse when o_link_address updates
//   o_align_fault          : (PC_ALIGN_CHECK_EN only) misaligned target pulse
// -----------------------------------------------------------------------------
module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    INSTR_BYTES  = 4
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_branch_valid,
  input  logic        [2:0]            i_branch_mode,
  input  logic                         i_zero_flag,
  input  logic        [ADDR_WIDTH-1:0] i_branch_base,
  input  logic signed [ADDR_WIDTH-1:0] i_branch_offset,
  input  logic        [ADDR_WIDTH-1:0] i_reg_target,
  input  logic                         i_fetch_ready,
  output logic                         o_fetch_valid,
  output logic        [ADDR_WIDTH-1:0] o_read_address,
  output logic                         o_redirect_taken,
  output logic        [ADDR_WIDTH-1:0] o_link_address,
  output logic                         o_link_valid
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic                         o_align_fault
`endif
);

  localparam logic [ADDR_WIDTH-1:0] INC = ADDR_WIDTH'(INSTR_BYTES);

  fetch_state_t          r_state, w_state_next;
  logic [ADDR_WIDTH-1:0] r_read_address, w_addr_next;
  logic [ADDR_WIDTH-1:0] r_pend_target, w_pend_next;
  logic [ADDR_WIDTH-1:0] r_link_address;
  logic                  r_redirect, r_link_valid;

  logic                  w_res_taken, w_is_link;
  logic [ADDR_WIDTH-1:0] w_res_target, w_target;
  logic                  w_accept, w_capture, w_apply;

  pc_branch_resolve #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_resolve (
    .i_mode       (i_branch_mode),
    .i_flag       (i_zero_flag),
    .i_base       (i_branch_base),
    .i_offset     (i_branch_offset),
    .i_reg_target (i_reg_target),
    .o_taken      (w_res_taken),
    .o_target     (w_res_target),
    .o_is_link    (w_is_link)
  );

  assign o_fetch_valid = (r_state != ST_IDLE);
  assign w_accept      = o_fetch_valid & i_fetch_ready;
  // Branches are only honoured in FETCH; in PENDING the presenting
  // instruction is on the wrong path and has already been flushed.
  assign w_capture     = i_branch_valid & w_res_taken & (r_state == ST_FETCH);

`ifdef PC_ALIGN_CHECK_EN
  logic w_misaligned;
  logic r_align_fault;
  assign w_misaligned  = |w_res_target[1:0];
  assign w_target      = w_res_target;
  assign w_apply       = w_capture & ~w_misaligned;
  assign o_align_fault = r_align_fault;

  always_ff @(posedge i_clock) begin
    if (i_reset) r_align_fault <= 1'b0;
    else         r_align_fault <= w_capture & w_misaligned;
  end
`else
  assign w_target = {w_res_target[ADDR_WIDTH-1:2], 2'b00};
  assign w_apply  = w_capture;
`endif

  // Next-state logic. A taken branch overrides the sequential increment; the
  // address only ever moves on an accept so a stalled request stays stable.
  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_read_address;
    w_pend_next  = r_pend_target;
    case (r_state)
      ST_IDLE: w_state_next = ST_FETCH;
      ST_FETCH: begin
        if (w_apply) begin
          if (w_accept) begin
            w_addr_next = w_target;
          end else begin
            w_pend_next  = w_target;
            w_state_next = ST_PENDING;
          end
        end else if (w_accept) begin
          w_addr_next = r_read_address + INC;
        end
      end
      ST_PENDING: begin
        if (w_accept) begin
          w_addr_next  = r_pend_target;
          w_state_next = ST_FETCH;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state        <= ST_IDLE;
      r_read_address <= RESET_VECTOR;
      r_pend_target  <= '0;
      r_redirect     <= 1'b0;
      r_link_valid   <= 1'b0;
      r_link_address <= '0;
    end else begin
      r_state        <= w_state_next;
      r_read_address <= w_addr_next;
      r_pend_target  <= w_pend_next;
      r_redirect     <= w_apply;
      r_link_valid   <= w_apply & w_is_link;
      if (w_apply && w_is_link) r_link_address <= i_branch_base + INC;
    end
  end

  assign o_read_address   = r_read_address;
  assign o_redirect_taken = r_redirect;
  assign o_link_address   = r_link_address;
  assign o_link_valid     = r_link_valid;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_unit
// Directed walk through the fetch unit's main scenarios followed by random
// traffic, all compared every cycle against a transaction-level model of the
// fetch stream (current request, a queue of deferred redirects, link state).
// -----------------------------------------------------------------------------
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, bv, zf, ready;
  logic [2:0]  mode;
  logic [31:0] base, off, regt;
  logic        fv, rt, lv;
  logic [31:0] ra, la;
`ifdef PC_ALIGN_CHECK_EN
  logic        af;
`endif

  int checks = 0;
  int errors = 0;

  pc_fetch_unit dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_branch_valid   (bv),
    .i_branch_mode    (mode),
    .i_zero_flag      (zf),
    .i_branch_base    (base),
    .i_branch_offset  (off),
    .i_reg_target     (regt),
    .i_fetch_ready    (ready),
    .o_fetch_valid    (fv),
    .o_read_address   (ra),
    .o_redirect_taken (rt),
    .o_link_address   (la),
    .o_link_valid     (lv)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .o_align_fault    (af)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_init = 1'b0;
  bit          m_valid, m_redirect, m_lv, m_fault;
  logic [31:0] m_addr, m_link;
  logic [31:0] m_pend[$];

  function automatic bit model_taken(input logic [2:0] md, input logic z);
    case (md)
      3'd1, 3'd2, 3'd5: return 1'b1;
      3'd3:             return z;
      3'd4:             return !z;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_target(input logic [2:0] md, input logic [31:0] b,
                                               input logic [31:0] o, input logic [31:0] r);
    logic [31:0] t;
    if (md == 3'd5) t = r;
    else            t = b + o * 32'd4;
    return t;
  endfunction

  always @(posedge clk) begin
    bit          acc, tk;
    logic [31:0] tg;
    acc = m_valid && ready;
    if (rst) begin
      m_init = 1'b1; m_valid = 1'b0; m_addr = 32'h0; m_link = 32'h0;
      m_redirect = 1'b0; m_lv = 1'b0; m_fault = 1'b0;
      m_pend.delete();
    end else if (m_init) begin
      m_redirect = 1'b0; m_lv = 1'b0; m_fault = 1'b0;
      if (!m_valid) begin
        m_valid = 1'b1;
      end else if (m_pend.size() > 0) begin
        if (acc) m_addr = m_pend.pop_front();
      end else begin
        tk = bv && model_taken(mode, zf);
        tg = model_target(mode, base, off, regt);
`ifdef PC_ALIGN_CHECK_EN
        if (tk && tg[1:0] != 2'b00) begin
          m_fault = 1'b1;
          tk = 1'b0;
        end
`else
        tg[1:0] = 2'b00;
`endif
        if (tk) begin
          m_redirect = 1'b1;
          if (mode == 3'd2) begin
            m_link = base + 32'd4;
            m_lv   = 1'b1;
          end
          if (acc) m_addr = tg;
          else     m_pend.push_back(tg);
        end else if (acc) begin
          m_addr = m_addr + 32'd4;
        end
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    if (m_init) begin
      chk("fetch_valid", {31'b0, fv}, {31'b0, m_valid});
      chk("read_address", ra, m_addr);
      chk("redirect_taken", {31'b0, rt}, {31'b0, m_redirect});
      chk("link_valid", {31'b0, lv}, {31'b0, m_lv});
      chk("link_address", la, m_link);
`ifdef PC_ALIGN_CHECK_EN
      chk("align_fault", {31'b0, af}, {31'b0, m_fault});
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic setbr(input logic v, input logic [2:0] md, input logic z,
                       input logic [31:0] b, input logic [31:0] o, input logic [31:0] r);
    bv = v; mode = md; zf = z; base = b; off = o; regt = r;
  endtask

  initial begin
    rst = 1'b1; ready = 1'b1;
    setbr(1'b0, 3'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    cyc();
    chk("rst_fetch_valid", {31'b0, fv}, 32'd0);
    chk("rst_read_address", ra, 32'h0);
    chk("rst_redirect", {31'b0, rt}, 32'd0);
    chk("rst_link_valid", {31'b0, lv}, 32'd0);
    chk("rst_link_address", la, 32'h0);

    rst = 1'b0;
    cyc(); chk("first_valid", {31'b0, fv}, 32'd1); chk("seq0", ra, 32'h0);
    cyc(); chk("seq4", ra, 32'h4);
    cyc(); chk("seq8", ra, 32'h8);
    cyc(); chk("seq12", ra, 32'hC);
    cyc(); chk("seq16", ra, 32'h10);

    setbr(1'b1, 3'd3, 1'b0, 32'hC, 32'd3, 32'h0);
    cyc(); chk("cbz_nt_addr", ra, 32'h14); chk("cbz_nt_redir", {31'b0, rt}, 32'd0);
    setbr(1'b1, 3'd3, 1'b1, 32'hC, 32'd3, 32'h0);
    cyc(); chk("cbz_t_addr", ra, 32'h18); chk("cbz_t_redir", {31'b0, rt}, 32'd1);
    bv = 1'b0;
    cyc(); chk("after_cbz_addr", ra, 32'h1C); chk("redir_once", {31'b0, rt}, 32'd0);
    cyc(); chk("at_0x20", ra, 32'h20);

    ready = 1'b0;
    setbr(1'b1, 3'd1, 1'b0, 32'h1C, 32'hFFFF_FFFE, 32'h0);
    cyc(); chk("stall_hold1", ra, 32'h20); chk("stall_redir", {31'b0, rt}, 32'd1);
    setbr(1'b1, 3'd1, 1'b0, 32'h0, 32'h100, 32'h0);
    cyc(); chk("stall_hold2", ra, 32'h20); chk("stall_ignore", {31'b0, rt}, 32'd0);
    bv = 1'b0;
    cyc(); chk("stall_hold3", ra, 32'h20);
    ready = 1'b1;
    cyc(); chk("pending_apply", ra, 32'h14);

    setbr(1'b1, 3'd2, 1'b0, 32'h40, 32'h10, 32'h0);
    cyc(); chk("bl_addr", ra, 32'h80); chk("bl_link", la, 32'h44);
    chk("bl_lv", {31'b0, lv}, 32'd1);
    bv = 1'b0;
    cyc(); chk("bl_lv_off", {31'b0, lv}, 32'd0); chk("bl_link_hold", la, 32'h44);
    chk("after_bl", ra, 32'h84);

    setbr(1'b1, 3'd5, 1'b0, 32'h0, 32'h0, 32'h1000);
    cyc(); chk("br_addr", ra, 32'h1000);
`ifdef PC_ALIGN_CHECK_EN
    setbr(1'b1, 3'd5, 1'b0, 32'h0, 32'h0, 32'h1002);
    cyc(); chk("align_fault_pulse", {31'b0, af}, 32'd1); chk("align_seq", ra, 32'h1004);
    chk("align_no_redir", {31'b0, rt}, 32'd0);
    bv = 1'b0;
    cyc(); chk("align_fault_off", {31'b0, af}, 32'd0); chk("align_seq2", ra, 32'h1008);
`endif

    setbr(1'b1, 3'd5, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC);
    cyc(); chk("wrap_top", ra, 32'hFFFF_FFFC);
    bv = 1'b0;
    cyc(); chk("wrap_zero", ra, 32'h0);
    cyc(); chk("wrap_four", ra, 32'h4);

    ready = 1'b0;
    setbr(1'b1, 3'd1, 1'b0, 32'h0, 32'h40, 32'h0);
    cyc(); chk("pend_hold", ra, 32'h4);
    bv = 1'b0; rst = 1'b1;
    cyc(); chk("pend_rst_valid", {31'b0, fv}, 32'd0); chk("pend_rst_addr", ra, 32'h0);
    rst = 1'b0; ready = 1'b1;
    cyc(); chk("pend_rst_restart", ra, 32'h0);
    cyc(); chk("pend_discarded", ra, 32'h4);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      int o;
      rst   = ($urandom_range(0, 199) == 0);
      ready = ($urandom_range(0, 9) < 7);
      bv    = ($urandom_range(0, 9) < 4);
      mode  = 3'($urandom_range(0, 7));
      zf    = 1'($urandom_range(0, 1));
      base  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      o     = int'($urandom_range(0, 127)) - 64;
      off   = o;
      regt  = ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
